// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache <-> main-memory line-transfer interface.
// Used by main_memory_responder and by the cache controller on the other side.
//   WORD_W     : width of one transferred word
//   LINE_WORDS : words per cache line (one beat per word)
//   OFFSET_W   : word-offset bits inside a line
//   INDEX_W    : cache index bits
//   TAG_W      : cache tag bits
//   ADDR_W     : full word-address width (tag | index | offset)
//   mem_state_e: responder state encoding
package cache_mem_pkg;

  localparam int WORD_W     = 64;
  localparam int LINE_WORDS = 8;
  localparam int OFFSET_W   = 3;
  localparam int INDEX_W    = 7;
  localparam int TAG_W      = 10;
  localparam int ADDR_W     = TAG_W + INDEX_W + OFFSET_W;

  // Beat number carrying the last word of a line.
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RWAIT  = 3'd1,
    RBURST = 3'd2,
    WBURST = 3'd3,
    WWAIT  = 3'd4,
    WDONE  = 3'd5
  } mem_state_e;

endpackage

// File: rtl/mem_line_ram.sv
// Backing store for the memory responder: 2^LINES_W lines of LINE_WORDS x WORD_W.
// Ports:
//   clk, rst_b          : clock, asynchronous active-low reset (read register only)
//   wr_en/wr_line/wr_word/wr_data : one-word write port
//   rd_en/rd_line/rd_word         : one-word read port
//   rd_data             : registered read word, cleared by reset
// The storage array itself is never reset; contents survive a reset.
module mem_line_ram
  import cache_mem_pkg::*;
#(
  parameter int LINES_W = 10
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                wr_en,
  input  logic [LINES_W-1:0]  wr_line,
  input  logic [OFFSET_W-1:0] wr_word,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                rd_en,
  input  logic [LINES_W-1:0]  rd_line,
  input  logic [OFFSET_W-1:0] rd_word,
  output logic [WORD_W-1:0]   rd_data
);

  localparam int DEPTH = (1 << LINES_W) * LINE_WORDS;

  logic [WORD_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_line, wr_word}] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[{rd_line, rd_word}];
    end
  end

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side end of the cache line-transfer interface. Serves line fills and
// dirty-line write-backs with a programmable access latency, one word per beat.
// Ports:
//   clk, rst_b            : clock, asynchronous active-low reset
//   req_valid/req_ready   : line request handshake (accepted when both high)
//   req_we                : 1 = write-back, 0 = fill; sampled at accept
//   req_addr              : word address, offset bits ignored
//   wr_valid/wr_ready     : write-back beat handshake
//   wr_data               : write-back beat, beat 0 = word 0
//   rd_valid/rd_data      : fill beats, no backpressure
//   rd_last               : marks beat 7 of a fill
//   done                  : one-cycle pulse when a write-back has committed
// Line-address bits above LINES_W are dropped, so such lines alias.
module main_memory_responder #(
  parameter int ADDR_W  = cache_mem_pkg::ADDR_W,
  parameter int LINES_W = 10,
  parameter int LATENCY = 4
) (
  input  logic                             clk,
  input  logic                             rst_b,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_W-1:0]                req_addr,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [cache_mem_pkg::WORD_W-1:0] wr_data,
  output logic                             rd_valid,
  output logic [cache_mem_pkg::WORD_W-1:0] rd_data,
  output logic                             rd_last,
  output logic                             done
);

  import cache_mem_pkg::*;

  // The latency counter runs 0..LATENCY-1; with LATENCY=0 the wait states are
  // never entered and the counter is a harmless single bit.
  localparam int LAT_LAST = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam int CNT_W    = (LAT_LAST > 0) ? $clog2(LAT_LAST + 1) : 1;

  mem_state_e          state;
  logic [LINES_W-1:0]  line_q;
  logic [OFFSET_W-1:0] beat_q;
  logic [CNT_W-1:0]    lat_q;
  logic                lat_hit;
  logic                accept;
  logic                wr_beat;
  logic                rd_beat;
  logic                unused_addr_bits;

  assign accept  = req_valid & req_ready;
  assign lat_hit = (lat_q == CNT_W'(LAT_LAST));
  assign wr_beat = (state == WBURST) & wr_valid;
  // Every RBURST cycle launches one word into the RAM's read register, which
  // is what makes rd_data line up with the registered rd_valid.
  assign rd_beat = (state == RBURST);

  // Offset bits and aliased upper line bits are intentionally dropped.
  assign unused_addr_bits = ^req_addr;

  mem_line_ram #(
    .LINES_W (LINES_W)
  ) u_ram (
    .clk     (clk),
    .rst_b   (rst_b),
    .wr_en   (wr_beat),
    .wr_line (line_q),
    .wr_word (beat_q),
    .wr_data (wr_data),
    .rd_en   (rd_beat),
    .rd_line (line_q),
    .rd_word (beat_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      line_q    <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            line_q    <= req_addr[OFFSET_W +: LINES_W];
            beat_q    <= '0;
            lat_q     <= '0;
            req_ready <= 1'b0;
            if (req_we) begin
              state    <= WBURST;
              wr_ready <= 1'b1;
            end else if (LATENCY == 0) begin
              state <= RBURST;
            end else begin
              state <= RWAIT;
            end
          end
        end
        RWAIT: begin
          if (lat_hit) begin
            lat_q <= '0;
            state <= RBURST;
          end else begin
            lat_q <= lat_q + CNT_W'(1);
          end
        end
        RBURST: begin
          rd_valid <= 1'b1;
          rd_last  <= (beat_q == LAST_BEAT);
          beat_q   <= beat_q + OFFSET_W'(1);
          if (beat_q == LAST_BEAT) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        WBURST: begin
          if (wr_valid) begin
            beat_q <= beat_q + OFFSET_W'(1);
            if (beat_q == LAST_BEAT) begin
              wr_ready <= 1'b0;
              state    <= (LATENCY == 0) ? WDONE : WWAIT;
            end
          end
        end
        WWAIT: begin
          if (lat_hit) begin
            lat_q <= '0;
            state <= WDONE;
          end else begin
            lat_q <= lat_q + CNT_W'(1);
          end
        end
        WDONE: begin
          done      <= 1'b1;
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          wr_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Bench for main_memory_responder. Keeps a word-level picture of memory plus a
// timeline of when each output event must happen, derived from accept/beat
// times and the latency, and checks the DUT against it every cycle. A second
// instance built with LATENCY=0 gets a short directed timing check.
`timescale 1ns/1ps
module tb_main_memory_responder;

  localparam int LAT = 4;
  localparam int LW  = 10;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        req_valid, req_ready, req_we;
  logic [19:0] req_addr;
  logic        wr_valid, wr_ready;
  logic [63:0] wr_data;
  logic        rd_valid, rd_last, done;
  logic [63:0] rd_data;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [19:0] z_req_addr;
  logic        z_wr_valid, z_wr_ready;
  logic [63:0] z_wr_data;
  logic        z_rd_valid, z_rd_last, z_done;
  logic [63:0] z_rd_data;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  // Model state: memory words keyed by line*8+word, and the output timeline.
  logic [63:0] mdl_mem  [int];
  bit          exp_rdv  [int];
  logic [63:0] exp_rdd  [int];
  bit          exp_last [int];
  bit          exp_done [int];
  int busy_start = 0;
  int ready_from = 0;
  int wr_from    = 0;
  int wr_until   = 0;
  bit chk_en     = 1'b0;

  int          obs_cyc  [$];
  logic [63:0] obs_data [$];
  bit          obs_last [$];
  int          done_cyc [$];

  always #5 clk = ~clk;

  // Edge counter: after posedge n settles, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  main_memory_responder #(.ADDR_W(20), .LINES_W(LW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .done(done)
  );

  main_memory_responder #(.ADDR_W(20), .LINES_W(LW), .LATENCY(0)) dut0 (
    .clk(clk), .rst_b(rst_b),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we), .req_addr(z_req_addr),
    .wr_valid(z_wr_valid), .wr_ready(z_wr_ready), .wr_data(z_wr_data),
    .rd_valid(z_rd_valid), .rd_data(z_rd_data), .rd_last(z_rd_last), .done(z_done)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  function automatic int lineOf(input logic [19:0] addr);
    return (int'(addr) >> 3) % (1 << LW);
  endfunction

  task automatic clearExpect();
    exp_rdv.delete();
    exp_rdd.delete();
    exp_last.delete();
    exp_done.delete();
    busy_start = 0;
    ready_from = 0;
    wr_from    = 0;
    wr_until   = 0;
  endtask

  // Asynchronous reset in the middle of a clock-high phase; outputs must
  // clear before any further edge.
  task automatic pulseReset();
    chk_en    = 1'b0;
    req_valid = 1'b0;
    wr_valid  = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    checkOutput("async_req_ready", 64'(req_ready), 64'd1);
    checkOutput("async_rd_valid",  64'(rd_valid),  64'd0);
    checkOutput("async_rd_last",   64'(rd_last),   64'd0);
    checkOutput("async_wr_ready",  64'(wr_ready),  64'd0);
    checkOutput("async_done",      64'(done),      64'd0);
    checkOutput("async_rd_data",   rd_data,        64'd0);
    clearExpect();
    repeat (3) @(posedge clk);
    #1;
    rst_b  = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (cyc < ready_from) begin
      applyStimulus();
      guard++;
      if (guard > 300) begin
        checkOutput("idle_timeout", 64'd0, 64'd1);
        break;
      end
    end
  endtask

  // Hold req_valid until the model says the responder is idle; returns the
  // accept edge. Junk on wr_valid meanwhile must be ignored by the DUT.
  task automatic waitAccept(output int a);
    int guard;
    guard = 0;
    while (cyc < ready_from) begin
      wr_valid = 1'($urandom_range(1));
      wr_data  = {$urandom, $urandom};
      applyStimulus();
      guard++;
      if (guard > 300) begin
        checkOutput("accept_timeout", 64'd0, 64'd1);
        break;
      end
    end
    wr_valid = 1'b0;
    a = cyc + 1;
    applyStimulus();
  endtask

  task automatic doRead(input logic [19:0] addr, output int a);
    int ln, key;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = addr;
    waitAccept(a);
    req_valid = 1'b0;
    req_we    = 1'($urandom_range(1));
    req_addr  = 20'($urandom);
    ln = lineOf(addr);
    for (int i = 0; i < 8; i++) begin
      key = ln * 8 + i;
      exp_rdv[a + LAT + 1 + i]  = 1'b1;
      exp_last[a + LAT + 1 + i] = (i == 7);
      if (mdl_mem.exists(key)) exp_rdd[a + LAT + 1 + i] = mdl_mem[key];
    end
    busy_start = a;
    ready_from = a + LAT + 8;
  endtask

  task automatic doWrite(input logic [19:0] addr, input logic [63:0] base, input logic [7:0] gap_mask,
                         input int gap_pct, input int abort_after, output int w7);
    int a, ln, b, guard;
    bit v, gap_pending;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = addr;
    waitAccept(a);
    req_valid = 1'b0;
    req_addr  = 20'($urandom);
    ln = lineOf(addr);
    busy_start = a;
    ready_from = 1 << 30;
    wr_from    = a;
    wr_until   = 1 << 30;
    b = 0;
    guard = 0;
    gap_pending = 1'b0;
    w7 = -1;
    while (b < 8) begin
      if (b == abort_after) begin
        pulseReset();
        return;
      end
      v = 1'b1;
      if (gap_pending) begin
        v = 1'b0;
        gap_pending = 1'b0;
      end else if ($urandom_range(99) < gap_pct) begin
        v = 1'b0;
      end
      wr_valid = v;
      wr_data  = v ? base + 64'(b) : {$urandom, $urandom};
      applyStimulus();
      if (v) begin
        mdl_mem[ln * 8 + b] = base + 64'(b);
        if (gap_mask[b]) gap_pending = 1'b1;
        b++;
      end
      guard++;
      if (guard > 300) begin
        checkOutput("wburst_timeout", 64'd0, 64'd1);
        break;
      end
    end
    wr_valid   = 1'b0;
    w7         = cyc;
    wr_until   = w7;
    ready_from = w7 + LAT + 1;
    exp_done[w7 + LAT + 1] = 1'b1;
    waitIdle();
  endtask

  // Per-cycle comparison against the model timeline, sampled on the falling edge.
  always @(negedge clk) begin : compare
    bit ev;
    if (chk_en && rst_b) begin
      ev = exp_rdv.exists(cyc);
      checkOutput("req_ready", 64'(req_ready), 64'(!(cyc >= busy_start && cyc < ready_from)));
      checkOutput("wr_ready",  64'(wr_ready),  64'(cyc >= wr_from && cyc < wr_until));
      checkOutput("rd_valid",  64'(rd_valid),  64'(ev));
      checkOutput("rd_last",   64'(rd_last),   64'(ev ? exp_last[cyc] : 1'b0));
      if (ev && exp_rdd.exists(cyc)) checkOutput("rd_data", rd_data, exp_rdd[cyc]);
      checkOutput("done",      64'(done),      64'(exp_done.exists(cyc)));
      if (rd_valid) begin
        obs_cyc.push_back(cyc);
        obs_data.push_back(rd_data);
        obs_last.push_back(rd_last);
      end
      if (done) done_cyc.push_back(cyc);
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int a, a2, w7, zc0, zn, zlast_n, zlast_at, zdone_n, zdone_at;
    int pool [6];
    logic [63:0] zd [$];
    int zc [$];
    int ln;
    logic [19:0] ad;

    rst_b = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    wr_valid = 1'b0;  wr_data = '0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0;
    z_wr_valid = 1'b0;  z_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_b  = 1'b1;
    chk_en = 1'b1;

    // Reset values.
    @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
    checkOutput("rst_rd_valid",  64'(rd_valid),  64'd0);
    checkOutput("rst_wr_ready",  64'(wr_ready),  64'd0);
    checkOutput("rst_done",      64'(done),      64'd0);

    // Preload line 0x05A, then fill it through a non-aligned address.
    doWrite(20'h002D0, 64'h100, 8'h00, 0, 8, w7);
    applyStimulus();
    obs_cyc.delete(); obs_data.delete(); obs_last.delete();
    doRead(20'h002D3, a);
    waitIdle();
    applyStimulus();
    checkOutput("fill_beats", 64'(obs_cyc.size()), 64'd8);
    if (obs_cyc.size() == 8) begin
      checkOutput("fill_first_lat", 64'(obs_cyc[0] - a), 64'd5);
      for (int i = 0; i < 8; i++) begin
        checkOutput("fill_data", obs_data[i], 64'h100 + 64'(i));
        checkOutput("fill_last", 64'(obs_last[i]), 64'(i == 7));
      end
    end

    // Write-back with gaps after beats 2 and 5, then fill it back.
    done_cyc.delete();
    doWrite(20'h01FF8, 64'hA0, 8'b0010_0100, 0, 8, w7);
    applyStimulus();
    checkOutput("wb_done_pulses", 64'(done_cyc.size()), 64'd1);
    if (done_cyc.size() == 1) checkOutput("wb_done_lat", 64'(done_cyc[0] - w7), 64'd5);
    obs_cyc.delete(); obs_data.delete(); obs_last.delete();
    doRead(20'h01FF8, a);
    waitIdle();
    applyStimulus();
    checkOutput("raw_beats", 64'(obs_cyc.size()), 64'd8);
    if (obs_cyc.size() == 8)
      for (int i = 0; i < 8; i++) checkOutput("raw_data", obs_data[i], 64'hA0 + 64'(i));

    // Second request held during a burst is accepted the first idle cycle.
    obs_cyc.delete(); obs_data.delete(); obs_last.delete();
    doRead(20'h002D0, a);
    doRead(20'h01FF8, a2);
    checkOutput("busy_accept_gap", 64'(a2 - a), 64'd13);
    waitIdle();
    applyStimulus();
    checkOutput("busy_beats", 64'(obs_cyc.size()), 64'd16);
    if (obs_cyc.size() == 16)
      for (int i = 0; i < 8; i++) checkOutput("busy_data", obs_data[8 + i], 64'hA0 + 64'(i));

    // Reset in the middle of a fill burst.
    doRead(20'h002D0, a);
    repeat (6) applyStimulus();
    pulseReset();

    // Reset mid write-back after 3 beats; read back through an aliased address.
    doWrite(20'h00600, 64'h300, 8'h00, 0, 8, w7);
    applyStimulus();
    done_cyc.delete();
    doWrite(20'h00600, 64'h400, 8'h00, 0, 3, w7);
    repeat (8) applyStimulus();
    checkOutput("abort_no_done", 64'(done_cyc.size()), 64'd0);
    obs_cyc.delete(); obs_data.delete(); obs_last.delete();
    doRead(20'hAA607, a);
    waitIdle();
    applyStimulus();
    checkOutput("abort_beats", 64'(obs_cyc.size()), 64'd8);
    if (obs_cyc.size() == 8)
      for (int i = 0; i < 8; i++)
        checkOutput("abort_data", obs_data[i], (i < 3) ? 64'h400 + 64'(i) : 64'h300 + 64'(i));

    // Randomized traffic over a pool of lines, with random tags for aliasing.
    pool = '{10'h05A, 10'h3FF, 10'h0C0, 10'h011, 10'h2A5, 10'h100};
    for (int k = 3; k < 6; k++) begin
      doWrite({7'($urandom), 10'(pool[k]), 3'($urandom)}, {$urandom, $urandom}, 8'h00, 20, 8, w7);
    end
    for (int n = 0; n < 40; n++) begin
      ln = pool[$urandom_range(5)];
      ad = {7'($urandom), 10'(ln), 3'($urandom)};
      if ($urandom_range(2) == 0)
        doWrite(ad, {$urandom, $urandom}, 8'($urandom), 30, 8, w7);
      else
        doRead(ad, a);
    end
    waitIdle();
    repeat (2) applyStimulus();

    // LATENCY=0 instance: write-back then fill of line 2.
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 20'h00010;
    @(negedge clk);
    checkOutput("z_req_ready", 64'(z_req_ready), 64'd1);
    applyStimulus();
    z_req_valid = 1'b0;
    @(negedge clk);
    checkOutput("z_wr_ready", 64'(z_wr_ready), 64'd1);
    for (int b = 0; b < 8; b++) begin
      z_wr_valid = 1'b1;
      z_wr_data  = 64'h200 + 64'(b);
      applyStimulus();
    end
    z_wr_valid = 1'b0;
    w7 = cyc;
    zdone_n = 0; zdone_at = -1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (z_done) begin
        zdone_n++;
        if (zdone_at < 0) zdone_at = cyc;
      end
    end
    checkOutput("z_done_pulses", 64'(zdone_n), 64'd1);
    checkOutput("z_done_lat", 64'(zdone_at - w7), 64'd1);
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 20'h00015;
    applyStimulus();
    zc0 = cyc;
    z_req_valid = 1'b0;
    zlast_n = 0; zlast_at = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (z_rd_valid) begin
        zc.push_back(cyc);
        zd.push_back(z_rd_data);
        if (z_rd_last) begin
          zlast_n++;
          zlast_at = zc.size();
        end
      end
    end
    zn = zc.size();
    checkOutput("z_fill_beats", 64'(zn), 64'd8);
    checkOutput("z_last_count", 64'(zlast_n), 64'd1);
    checkOutput("z_last_pos", 64'(zlast_at), 64'd8);
    if (zn == 8) begin
      checkOutput("z_first_lat", 64'(zc[0] - zc0), 64'd1);
      for (int i = 0; i < 8; i++) checkOutput("z_fill_data", zd[i], 64'h200 + 64'(i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
